// File: rtl/pong_pkg.sv
// Shared Pong constants: screen geometry, paddle motion defaults and the
// state encoding used by the game FSMs.
package pong_pkg;

  localparam int SCREEN_H         = 480;
  localparam int PADDLE_H         = 72;
  localparam int Y_WIDTH          = 10;
  localparam int PADDLE_Y_MAX     = SCREEN_H - PADDLE_H;
  localparam int PADDLE_Y_INIT    = PADDLE_Y_MAX / 2;
  localparam int STEP_DEF         = 4;
  localparam int HOLD_TICKS_DEF   = 32;
  localparam int REPEAT_TICKS_DEF = 4;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'd0,
    FSM_HOLD   = 2'd1,
    FSM_REPEAT = 2'd2
  } fsm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/paddle_ctrl_btn_edge.sv
// Button history register: presents the current level, the previous-cycle
// level and a one-cycle rise indication.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic level,
  output logic prev,
  output logic rise
);

  logic prev_d;
  logic prev_q;

  // next history value is simply the current level
  always_comb begin
    prev_d = level_in;
  end

  // history register, tracked every cycle regardless of gameplay state
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign level = level_in;
  assign prev  = prev_q;
  assign rise  = level_in & ~prev_q;

endmodule

// File: rtl/paddle_ctrl.sv
// Pong paddle position controller: single step on press, auto-repeat after a
// hold delay, position clamped to the playfield.
module paddle_ctrl #(
  parameter int Y_WIDTH      = pong_pkg::Y_WIDTH,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = pong_pkg::PADDLE_Y_MAX,
  parameter int Y_INIT       = pong_pkg::PADDLE_Y_INIT,
  parameter int STEP         = pong_pkg::STEP_DEF,
  parameter int HOLD_TICKS   = pong_pkg::HOLD_TICKS_DEF,
  parameter int REPEAT_TICKS = pong_pkg::REPEAT_TICKS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_db,
  input  logic               down_db,
  input  logic               move_tick,
  input  logic               enable,
  output logic [Y_WIDTH-1:0] paddle_y,
  output logic               moving,
  output logic               at_top,
  output logic               at_bottom
);

  import pong_pkg::*;

  localparam int CNT_W = $clog2(max_int(HOLD_TICKS, REPEAT_TICKS)) + 1;
  localparam int YE_W  = Y_WIDTH + 1;

  localparam logic [CNT_W-1:0]   HOLD_LAST   = CNT_W'(HOLD_TICKS - 1);
  localparam logic [CNT_W-1:0]   REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [YE_W-1:0]    UP_LIM      = YE_W'(Y_MIN + STEP);
  localparam logic [YE_W-1:0]    DN_LIM      = YE_W'(Y_MAX - STEP);
  localparam logic [Y_WIDTH-1:0] Y_MIN_V     = Y_WIDTH'(Y_MIN);
  localparam logic [Y_WIDTH-1:0] Y_MAX_V     = Y_WIDTH'(Y_MAX);
  localparam logic [Y_WIDTH-1:0] Y_INIT_V    = Y_WIDTH'(Y_INIT);
  localparam logic [Y_WIDTH-1:0] STEP_V      = Y_WIDTH'(STEP);

  logic up_lvl, up_prev, up_rise;
  logic down_lvl, down_prev, down_rise;

  btn_edge u_up_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (up_db),
    .level    (up_lvl),
    .prev     (up_prev),
    .rise     (up_rise)
  );

  btn_edge u_down_edge (
    .clk      (clk),
    .reset    (reset),
    .level_in (down_db),
    .level    (down_lvl),
    .prev     (down_prev),
    .rise     (down_rise)
  );

  fsm_state_e         state_q, state_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Y_WIDTH-1:0] y_q, y_d;
  logic               moving_q, moving_d;
  logic               step_en;
  logic               step_down;
  logic               both_high;
  logic               lat_held;
  logic [YE_W-1:0]    y_ext;

  // state register and datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FSM_IDLE;
      dir_q    <= 1'b0;
      cnt_q    <= '0;
      y_q      <= Y_INIT_V;
      moving_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      moving_q <= moving_d;
    end
  end

  assign both_high = up_lvl & down_lvl;
  // "held" means high now and last cycle, so a fresh level never sustains a hold
  assign lat_held  = dir_q ? (down_lvl & down_prev) : (up_lvl & up_prev);

  // next-state logic: press detection, hold/repeat tick counting, exits
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    step_en   = 1'b0;
    step_down = dir_q;
    if (!enable) begin
      state_d = FSM_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FSM_IDLE: begin
          if (up_rise && !down_lvl) begin
            step_en   = 1'b1;
            step_down = 1'b0;
            dir_d     = 1'b0;
            cnt_d     = '0;
            state_d   = FSM_HOLD;
          end else if (down_rise && !up_lvl) begin
            step_en   = 1'b1;
            step_down = 1'b1;
            dir_d     = 1'b1;
            cnt_d     = '0;
            state_d   = FSM_HOLD;
          end else begin
            state_d = FSM_IDLE;
          end
        end
        FSM_HOLD: begin
          if (!lat_held || both_high) begin
            state_d = FSM_IDLE;
            cnt_d   = '0;
          end else if (move_tick) begin
            if (cnt_q == HOLD_LAST) begin
              step_en = 1'b1;
              cnt_d   = '0;
              state_d = FSM_REPEAT;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        FSM_REPEAT: begin
          if (!lat_held || both_high) begin
            state_d = FSM_IDLE;
            cnt_d   = '0;
          end else if (move_tick) begin
            if (cnt_q == REPEAT_LAST) begin
              step_en = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = FSM_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign y_ext = {1'b0, y_q};

  // output logic: clamped step; comparisons are done one bit wider so no wrap
  always_comb begin
    y_d = y_q;
    if (step_en) begin
      if (step_down) begin
        if (y_ext >= DN_LIM) begin
          y_d = Y_MAX_V;
        end else begin
          y_d = y_q + STEP_V;
        end
      end else begin
        if (y_ext <= UP_LIM) begin
          y_d = Y_MIN_V;
        end else begin
          y_d = y_q - STEP_V;
        end
      end
    end else begin
      y_d = y_q;
    end
    moving_d = (y_d != y_q);
  end

  assign paddle_y  = y_q;
  assign moving    = moving_q;
  assign at_top    = (y_q == Y_MIN_V);
  assign at_bottom = (y_q == Y_MAX_V);

endmodule
